// File: rtl/pdp_acc_core_if.sv
// Command and status bundle of the PDP accumulator core (master = host, slave = core).
// Latency: none, plain signal grouping.
// Backpressure: none; commands are fire-and-forget strobes. bp_hit exists only with PDP_BREAKPOINT_EN.
interface pdp_acc_core_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          cmd_valid;
    logic [2:0]    cmd;
    logic [DW-1:0] cmd_arg;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          carry;
    logic          busy;
    logic          halted;
`ifdef PDP_BREAKPOINT_EN
    logic          bp_hit;
`endif

    modport master (
        output cmd_valid, cmd, cmd_arg,
`ifdef PDP_BREAKPOINT_EN
        input  bp_hit,
`endif
        input  pc, acc, carry, busy, halted
    );

    modport slave (
        input  cmd_valid, cmd, cmd_arg,
`ifdef PDP_BREAKPOINT_EN
        output bp_hit,
`endif
        output pc, acc, carry, busy, halted
    );
endinterface

// File: rtl/pdp_acc_core.sv
// Accumulator micro-CPU: 2**AW slots of {3-bit opcode, DW-bit operand}, loaded via command port.
// Latency: every command/instruction takes effect on the next clock edge; outputs are registered.
// Backpressure: none; commands not accepted in the current state are dropped. Optional macro: PDP_BREAKPOINT_EN.
module pdp_acc_core #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic           i_clock,
    input  logic           i_reset,
    pdp_acc_core_if.slave  io
);
    localparam logic [2:0] CMD_SETPC  = 3'd0;
    localparam logic [2:0] CMD_LDCODE = 3'd1;
    localparam logic [2:0] CMD_LDDATA = 3'd2;
    localparam logic [2:0] CMD_STEP   = 3'd3;
    localparam logic [2:0] CMD_RUN    = 3'd4;
    localparam logic [2:0] CMD_STOP   = 3'd5;
`ifdef PDP_BREAKPOINT_EN
    localparam logic [2:0] CMD_SETBP  = 3'd6;
`endif

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_STORE = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_BZ    = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_BNZ   = 3'd5;
    localparam logic [2:0] OP_JMP   = 3'd6;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_acc;
    logic          r_carry;
    logic [2:0]    r_code [0:(1<<AW)-1];
    logic [DW-1:0] r_data [0:(1<<AW)-1];
`ifdef PDP_BREAKPOINT_EN
    logic [AW-1:0] r_bp;
    logic          r_bp_vld;
    logic          r_bp_skip;   // set on RUN entry so the breakpoint slot itself can execute
    logic          r_bp_hit;
`endif

    logic [2:0]    w_op;
    logic [DW-1:0] w_arg;
    logic [AW-1:0] w_npc;
    logic [DW:0]   w_sum;
    logic [DW:0]   w_dif;
    logic [AW-1:0] w_x_pc;
    logic [DW-1:0] w_x_acc;
    logic          w_x_carry;
    logic          w_x_halt;
    logic          w_x_store;
    logic          w_stop;
    logic          w_bp_stop;
    logic          w_exec;
    logic          w_ld_code;
    logic          w_ld_data;
    logic          w_data_we;
    logic [AW-1:0] w_data_addr;
    logic [DW-1:0] w_data_wdat;

    assign w_op  = r_code[r_pc];
    assign w_arg = r_data[r_pc];
    assign w_npc = r_pc + 1'b1;
    assign w_sum = {1'b0, r_acc} + {1'b0, w_arg};
    assign w_dif = {1'b0, r_acc} - {1'b0, w_arg};   // MSB is the borrow

    assign w_stop    = io.cmd_valid && (io.cmd == CMD_STOP);
`ifdef PDP_BREAKPOINT_EN
    assign w_bp_stop = (r_state == S_RUN) && r_bp_vld && !r_bp_skip && (r_pc == r_bp);
`else
    assign w_bp_stop = 1'b0;
`endif
    // STEP executes from IDLE regardless of breakpoints; RUN executes unless stopped this cycle
    assign w_exec = ((r_state == S_IDLE) && io.cmd_valid && (io.cmd == CMD_STEP)) ||
                    ((r_state == S_RUN) && !w_stop && !w_bp_stop);
    assign w_ld_code = (r_state == S_IDLE) && io.cmd_valid && (io.cmd == CMD_LDCODE);
    assign w_ld_data = (r_state == S_IDLE) && io.cmd_valid && (io.cmd == CMD_LDDATA);

    assign w_data_we   = w_ld_data || (w_exec && w_x_store);
    assign w_data_addr = w_ld_data ? r_pc : w_arg[AW-1:0];
    assign w_data_wdat = w_ld_data ? io.cmd_arg : r_acc;

    // Next architectural state if the instruction at pc were executed this cycle
    always_comb begin
        w_x_pc    = w_npc;
        w_x_acc   = r_acc;
        w_x_carry = r_carry;
        w_x_halt  = 1'b0;
        w_x_store = 1'b0;
        case (w_op)
            OP_LOAD:  w_x_acc = w_arg;
            OP_STORE: w_x_store = 1'b1;
            OP_ADD:   {w_x_carry, w_x_acc} = w_sum;
            OP_BZ:    if (r_acc == '0) w_x_pc = w_arg[AW-1:0];
            OP_SUB:   {w_x_carry, w_x_acc} = w_dif;
            OP_BNZ:   if (r_acc != '0) w_x_pc = w_arg[AW-1:0];
            OP_JMP:   w_x_pc = w_arg[AW-1:0];
            default: begin
                w_x_pc   = r_pc;
                w_x_halt = 1'b1;
            end
        endcase
    end

    // Program and data storage; contents survive reset but a reset cycle blocks writes
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            if (w_ld_code) r_code[r_pc] <= io.cmd_arg[2:0];
            if (w_data_we) r_data[w_data_addr] <= w_data_wdat;
        end
    end

    // Control FSM with pc/acc/carry and breakpoint registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
`ifdef PDP_BREAKPOINT_EN
            r_bp      <= '0;
            r_bp_vld  <= 1'b0;
            r_bp_skip <= 1'b0;
            r_bp_hit  <= 1'b0;
`endif
        end else begin
`ifdef PDP_BREAKPOINT_EN
            r_bp_hit  <= 1'b0;
            r_bp_skip <= 1'b0;
`endif
            if (w_exec) begin
                r_pc    <= w_x_pc;
                r_acc   <= w_x_acc;
                r_carry <= w_x_carry;
                if (w_x_halt) r_state <= S_HALT;
            end
            case (r_state)
                S_IDLE: begin
                    if (io.cmd_valid) begin
                        case (io.cmd)
                            CMD_SETPC: begin
                                r_pc  <= io.cmd_arg[AW-1:0];
                                r_acc <= '0;
                            end
                            CMD_LDCODE, CMD_LDDATA: r_pc <= w_npc;
                            CMD_RUN: begin
                                r_state <= S_RUN;
`ifdef PDP_BREAKPOINT_EN
                                r_bp_skip <= 1'b1;
`endif
                            end
`ifdef PDP_BREAKPOINT_EN
                            CMD_SETBP: begin
                                if (io.cmd_arg[DW-1]) begin
                                    r_bp_vld <= 1'b0;
                                end else begin
                                    r_bp     <= io.cmd_arg[AW-1:0];
                                    r_bp_vld <= 1'b1;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                    end else if (w_bp_stop) begin
                        r_state <= S_IDLE;
`ifdef PDP_BREAKPOINT_EN
                        r_bp_hit <= 1'b1;
`endif
                    end
                end
                S_HALT: begin
                    if (io.cmd_valid && (io.cmd == CMD_SETPC)) begin
                        r_pc    <= io.cmd_arg[AW-1:0];
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io.pc     = r_pc;
    assign io.acc    = r_acc;
    assign io.carry  = r_carry;
    assign io.busy   = (r_state == S_RUN);
    assign io.halted = (r_state == S_HALT);
`ifdef PDP_BREAKPOINT_EN
    assign io.bp_hit = r_bp_hit;
`endif
endmodule

// File: tb/tb_pdp_acc_core.sv
// Self-checking bench for pdp_acc_core (DW=4, AW=3): vector table plus run/breakpoint sequences.
// Latency: checks sample outputs 1 time unit after each rising edge.
// Backpressure: not applicable; commands are single-cycle strobes.
module tb_pdp_acc_core;
    localparam logic [2:0] SETPC = 3'd0, LDCODE = 3'd1, LDDATA = 3'd2, STEP = 3'd3;
    localparam logic [2:0] RUN = 3'd4, STOP = 3'd5, SETBP = 3'd6, NOP = 3'd7;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    pdp_acc_core_if #(.DW(4), .AW(3)) io ();

    pdp_acc_core #(.DW(4), .AW(3)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io      (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] cmd;
        logic [3:0] arg;
        logic [2:0] pc;
        logic [3:0] acc;
        logic       c;
        logic       b;
        logic       h;
        string      nm;
    } vec_t;

    typedef struct {
        logic [2:0] pc;
        logic [3:0] acc;
        logic       c;
        logic       b;
        logic       h;
        logic       bp;
        string      nm;
    } exp_t;

    vec_t vt[$];
    exp_t sb[$];

    function automatic void add(input logic r, input logic v, input logic [2:0] cm, input logic [3:0] a,
                                input logic [2:0] pc, input logic [3:0] acc, input logic c,
                                input logic b, input logic h, input string nm);
        vec_t x;
        x.rst = r; x.vld = v; x.cmd = cm; x.arg = a;
        x.pc = pc; x.acc = acc; x.c = c; x.b = b; x.h = h; x.nm = nm;
        vt.push_back(x);
    endfunction

    task automatic drive(input logic r, input logic v, input logic [2:0] cm, input logic [3:0] a);
        rst          = r;
        io.cmd_valid = v;
        io.cmd       = cm;
        io.cmd_arg   = a;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [2:0] cm, input logic [3:0] a);
        drive(1'b0, 1'b1, cm, a);
        tick();
        drive(1'b0, 1'b0, NOP, 4'd0);
    endtask

    task automatic check(input string nm, input logic [2:0] pc, input logic [3:0] acc,
                         input logic c, input logic b, input logic h, input logic bp);
        logic [10:0] got;
        logic [10:0] want;
        logic        bpg;
`ifdef PDP_BREAKPOINT_EN
        bpg = io.bp_hit;
`else
        bpg = 1'b0;
`endif
        got  = {io.pc, io.acc, io.carry, io.busy, io.halted, bpg};
        want = {pc, acc, c, b, h, bp};
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got pc=%0d acc=%0d carry=%0b busy=%0b halted=%0b bp=%0b, want pc=%0d acc=%0d carry=%0b busy=%0b halted=%0b bp=%0b",
                     nm, io.pc, io.acc, io.carry, io.busy, io.halted, bpg, pc, acc, c, b, h, bp);
        end
    endtask

    // Ticks until halted with a cycle budget; counts cycles that show busy before HALT.
    task automatic run_to_halt(input string nm, output int busy_cnt);
        bit done;
        busy_cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (io.halted === 1'b1) begin
                done = 1'b1;
            end else begin
                if (io.busy === 1'b1) busy_cnt++;
                tick();
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: halted=%0b after 20 cycles, want 1", nm, io.halted);
        end
    endtask

    initial begin
        exp_t e;
        int   bc;
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 1'b0, NOP, 4'd0);

        // reset, then data[0] survives a reset that coincides with LDDATA
        add(1, 0, NOP,    0, 0, 0, 0, 0, 0, "reset_state");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0");
        add(0, 1, LDCODE, 0, 1, 0, 0, 0, 0, "ldcode_load");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0_b");
        add(0, 1, LDDATA, 5, 1, 0, 0, 0, 0, "lddata5");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0_c");
        add(1, 1, LDDATA, 9, 0, 0, 0, 0, 0, "reset_vs_lddata_1");
        add(1, 1, LDDATA, 9, 0, 0, 0, 0, 0, "reset_vs_lddata_2");
        add(0, 1, STEP,   0, 1, 5, 0, 0, 0, "data0_kept");
        // load with pc wrap, then confirm code[0]=BZ and code[7]=ADD by stepping
        add(0, 1, SETPC,  6, 6, 0, 0, 0, 0, "setpc6");
        add(0, 1, LDCODE, 1, 7, 0, 0, 0, 0, "ldcode_slot6");
        add(0, 1, LDCODE, 2, 0, 0, 0, 0, 0, "ldcode_slot7_wrap");
        add(0, 1, LDCODE, 3, 1, 0, 0, 0, 0, "ldcode_slot0_pc1");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0_d");
        add(0, 1, STEP,   0, 5, 0, 0, 0, 0, "code0_is_bz");
        add(0, 1, SETPC,  7, 7, 0, 0, 0, 0, "setpc7");
        add(0, 1, LDDATA, 3, 0, 0, 0, 0, 0, "lddata_slot7");
        add(0, 1, SETPC,  7, 7, 0, 0, 0, 0, "setpc7_b");
        add(0, 1, STEP,   0, 0, 3, 0, 0, 0, "code7_is_add");
        // branching and SUB borrow
        add(0, 1, SETPC,  2, 2, 0, 0, 0, 0, "setpc2");
        add(0, 1, LDCODE, 3, 3, 0, 0, 0, 0, "code2_bz");
        add(0, 1, SETPC,  2, 2, 0, 0, 0, 0, "setpc2_b");
        add(0, 1, LDDATA, 5, 3, 0, 0, 0, 0, "data2_5");
        add(0, 1, SETPC,  2, 2, 0, 0, 0, 0, "setpc2_c");
        add(0, 1, STEP,   0, 5, 0, 0, 0, 0, "bz_taken");
        add(0, 1, SETPC,  6, 6, 0, 0, 0, 0, "setpc6_b");
        add(0, 1, LDCODE, 4, 7, 0, 0, 0, 0, "code6_sub");
        add(0, 1, SETPC,  6, 6, 0, 0, 0, 0, "setpc6_c");
        add(0, 1, LDDATA, 4, 7, 0, 0, 0, 0, "data6_4");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0_e");
        add(0, 1, LDCODE, 0, 1, 0, 0, 0, 0, "code0_load");
        add(0, 1, LDCODE, 6, 2, 0, 0, 0, 0, "code1_jmp");
        add(0, 1, LDCODE, 5, 3, 0, 0, 0, 0, "code2_bnz");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0_f");
        add(0, 1, LDDATA, 3, 1, 0, 0, 0, 0, "data0_3");
        add(0, 1, LDDATA, 2, 2, 0, 0, 0, 0, "data1_2");
        add(0, 1, LDDATA, 6, 3, 0, 0, 0, 0, "data2_6");
        add(0, 1, SETPC,  0, 0, 0, 0, 0, 0, "setpc0_g");
        add(0, 1, STEP,   0, 1, 3, 0, 0, 0, "step_load3");
        add(0, 1, STEP,   0, 2, 3, 0, 0, 0, "step_jmp2");
        add(0, 1, STEP,   0, 6, 3, 0, 0, 0, "bnz_taken");
        add(0, 1, STEP,   0, 7, 15, 1, 0, 0, "sub_borrow");
        add(0, 1, STEP,   0, 0, 2, 1, 0, 0, "add_carry_pc_wrap");
        // stop and ignore
        add(0, 1, SETPC,  0, 0, 0, 1, 0, 0, "setpc0_h");
        add(0, 1, LDCODE, 6, 1, 0, 1, 0, 0, "code0_jmp");
        add(0, 1, SETPC,  0, 0, 0, 1, 0, 0, "setpc0_i");
        add(0, 1, LDDATA, 0, 1, 0, 1, 0, 0, "data0_0");
        add(0, 1, SETPC,  0, 0, 0, 1, 0, 0, "setpc0_j");
        add(0, 1, RUN,    0, 0, 0, 1, 1, 0, "run_enter");
        add(0, 1, LDCODE, 7, 0, 0, 1, 1, 0, "ldcode_in_run");
        add(0, 1, STEP,   0, 0, 0, 1, 1, 0, "step_in_run");
        add(0, 1, STOP,   0, 0, 0, 1, 0, 0, "stop");
        add(0, 1, STEP,   0, 0, 0, 1, 0, 0, "code0_still_jmp");
        add(0, 1, NOP,    5, 0, 0, 1, 0, 0, "cmd7_noop");
        add(0, 1, SETBP, 10, 0, 0, 1, 0, 0, "setbp_disarm_noop");
        add(0, 1, SETPC,  3, 3, 0, 1, 0, 0, "setpc3");
        add(0, 1, LDCODE, 7, 4, 0, 1, 0, 0, "code3_halt");
        add(0, 1, SETPC,  3, 3, 0, 1, 0, 0, "setpc3_b");
        add(0, 1, STEP,   0, 3, 0, 1, 0, 1, "step_halt");
        add(0, 1, STEP,   0, 3, 0, 1, 0, 1, "halt_ignores_step");
        add(0, 1, LDDATA, 5, 3, 0, 1, 0, 1, "halt_ignores_lddata");
        add(0, 1, SETPC,  2, 2, 0, 1, 0, 0, "halt_setpc2");

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].vld, vt[i].cmd, vt[i].arg);
            e.pc = vt[i].pc; e.acc = vt[i].acc; e.c = vt[i].c;
            e.b = vt[i].b; e.h = vt[i].h; e.bp = 1'b0; e.nm = vt[i].nm;
            sb.push_back(e);
            tick();
            e = sb.pop_front();
            check(e.nm, e.pc, e.acc, e.c, e.b, e.h, e.bp);
        end
        drive(1'b0, 1'b0, NOP, 4'd0);

        // sum program: LOAD 9, ADD 8, STORE ->7, HALT
        do_cmd(SETPC, 0);
        do_cmd(LDCODE, 0); do_cmd(LDCODE, 2); do_cmd(LDCODE, 1); do_cmd(LDCODE, 7);
        do_cmd(SETPC, 0);
        do_cmd(LDDATA, 9); do_cmd(LDDATA, 8); do_cmd(LDDATA, 7);
        do_cmd(SETPC, 0);
        do_cmd(RUN, 0);
        check("sum_run_first", 0, 0, 1, 1, 0, 0);
        run_to_halt("sum", bc);
        n_tests++;
        if (bc != 4) begin
            n_fail++;
            $display("FAIL sum_busy_cycles: got %0d, want 4", bc);
        end
        check("sum_halt", 3, 1, 1, 0, 1, 0);
        do_cmd(SETPC, 7);
        check("sum_resume_pc7", 7, 1, 1, 0, 0, 0);
        do_cmd(STEP, 0);
        check("data7_is_1", 0, 2, 0, 0, 0, 0);

`ifdef PDP_BREAKPOINT_EN
        do_cmd(SETBP, 2);
        do_cmd(SETPC, 0);
        do_cmd(RUN, 0);
        tick();
        tick();
        tick();
        check("bp_hit_pulse", 2, 1, 1, 0, 0, 1);
        tick();
        check("bp_hit_clears", 2, 1, 1, 0, 0, 0);
        do_cmd(RUN, 0);
        check("bp_rerun_no_retrigger", 2, 1, 1, 1, 0, 0);
        run_to_halt("bp_rerun", bc);
        check("bp_rerun_halt", 3, 1, 1, 0, 1, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
